systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_feeder_buf.sv | 45 ++++
 rtl/systolic_feeder.sv | 146 ++++++++++++++
 tb/tb_systolic_feeder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared widths, default tile geometry and the feeder state type
// for the systolic array slice.
package systolic_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int N_DEF  = 4;
    localparam int K_DEF  = 4;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        S_LOAD,
        S_CLEAR,
        S_STREAM,
        S_DRAIN
    } feeder_state_e;

endpackage

// File: rtl/systolic_feeder_buf.sv
// KxN A/B register files: written one beat per row, read back
// skewed so that lane l at stream index t sees row t-l.
module feeder_buf
    import systolic_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [CNT_W-1:0]      i_wa,
    input  logic [N*DATA_W-1:0]   i_a,
    input  logic [N*DATA_W-1:0]   i_b,
    input  logic [CNT_W-1:0]      i_t,
    output logic [N*DATA_W-1:0]   o_west,
    output logic [N*DATA_W-1:0]   o_north
);

    logic [N*DATA_W-1:0] r_a [K];
    logic [N*DATA_W-1:0] r_b [K];

    // No reset: every row is rewritten by a load before it is read.
    always_ff @(posedge clk) begin
        for (int r = 0; r < K; r++) begin
            if (i_we && i_wa == CNT_W'(r)) begin
                r_a[r] <= i_a;
                r_b[r] <= i_b;
            end
        end
    end

    always_comb begin
        o_west  = '0;
        o_north = '0;
        for (int r = 0; r < K; r++) begin
            for (int l = 0; l < N; l++) begin
                if (int'(i_t) == r + l) begin
                    o_west[l*DATA_W +: DATA_W]  = r_a[r][l*DATA_W +: DATA_W];
                    o_north[l*DATA_W +: DATA_W] = r_b[r][l*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Tile loader and skew generator for an NxN systolic array.
// Define SYSTOLIC_FEEDER_TILE_CNT_EN to add the tile_cnt output.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   in_a,
    input  logic [N*DATA_W-1:0]   in_b,
    output logic [N*DATA_W-1:0]   west_out,
    output logic [N*DATA_W-1:0]   north_out,
    output logic                  arr_clr,
    output logic                  busy,
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
    output logic [15:0]           tile_cnt,
`endif
    output logic                  done
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] LAST_T    = CNT_W'(K + N - 1);
    localparam logic [CNT_W-1:0] LAST_D    = CNT_W'(N);
    localparam logic [CNT_W-1:0] PRE_D     = CNT_W'(N - 1);

    feeder_state_e         r_state;
    logic [CNT_W-1:0]      r_beat;
    logic [CNT_W-1:0]      r_t;
    logic [CNT_W-1:0]      r_drain;
    logic                  r_in_ready;
    logic                  r_arr_clr;
    logic                  r_busy;
    logic                  r_done;
    logic [N*DATA_W-1:0]   r_west;
    logic [N*DATA_W-1:0]   r_north;

    logic                  w_we;
    logic [N*DATA_W-1:0]   w_west;
    logic [N*DATA_W-1:0]   w_north;

    assign w_we = in_valid & r_in_ready;

    feeder_buf #(.N(N), .K(K)) u_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_wa    (r_beat),
        .i_a     (in_a),
        .i_b     (in_b),
        .i_t     (r_t),
        .o_west  (w_west),
        .o_north (w_north)
    );

    // r_t always holds the index of the next stream cycle to be emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_beat     <= '0;
            r_t        <= '0;
            r_drain    <= '0;
            r_in_ready <= 1'b1;
            r_arr_clr  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_west     <= '0;
            r_north    <= '0;
        end else begin
            r_arr_clr <= 1'b0;
            r_done    <= 1'b0;
            unique case (r_state)
                S_LOAD: begin
                    if (w_we) begin
                        if (r_beat == LAST_BEAT) begin
                            r_beat     <= '0;
                            r_state    <= S_CLEAR;
                            r_in_ready <= 1'b0;
                            r_arr_clr  <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_beat <= r_beat + ONE;
                        end
                    end
                end
                S_CLEAR: begin
                    r_state <= S_STREAM;
                    r_west  <= w_west;
                    r_north <= w_north;
                    r_t     <= ONE;
                end
                S_STREAM: begin
                    if (r_t == LAST_T) begin
                        r_state <= S_DRAIN;
                        r_west  <= '0;
                        r_north <= '0;
                        r_t     <= '0;
                        r_drain <= ONE;
                    end else begin
                        r_west  <= w_west;
                        r_north <= w_north;
                        r_t     <= r_t + ONE;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == LAST_D) begin
                        r_state    <= S_LOAD;
                        r_drain    <= '0;
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_drain <= r_drain + ONE;
                        r_done  <= (r_drain == PRE_D);
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign arr_clr   = r_arr_clr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign west_out  = r_west;
    assign north_out = r_north;

`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
    logic [15:0] r_tile_cnt;

    // Steps on the same edge that raises done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tile_cnt <= '0;
        end else if (r_state == S_DRAIN && r_drain == PRE_D) begin
            r_tile_cnt <= r_tile_cnt + 16'd1;
        end
    end

    assign tile_cnt = r_tile_cnt;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4,K=4 plus an N=4,K=1 copy).
module tb_systolic_feeder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        rdy;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] west;
    logic [31:0] north;
    logic        clr;
    logic        bsy;
    logic        dn;

    logic        k1_valid;
    logic        k1_rdy;
    logic [31:0] k1_west;
    logic [31:0] k1_north;
    logic        k1_clr;
    logic        k1_bsy;
    logic        k1_dn;

`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
    logic [15:0] tcnt;
    logic [15:0] k1_tcnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] ta [4];
    logic [31:0] tbv [4];
    logic [31:0] tw [7];
    logic [31:0] tn [7];

    systolic_feeder #(.N(4), .K(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (rdy),
        .in_a      (in_a),
        .in_b      (in_b),
        .west_out  (west),
        .north_out (north),
        .arr_clr   (clr),
        .busy      (bsy),
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        .tile_cnt  (tcnt),
`endif
        .done      (dn)
    );

    systolic_feeder #(.N(4), .K(1)) dut_k1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (k1_valid),
        .in_ready  (k1_rdy),
        .in_a      (in_a),
        .in_b      (in_b),
        .west_out  (k1_west),
        .north_out (k1_north),
        .arr_clr   (k1_clr),
        .busy      (k1_bsy),
`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        .tile_cnt  (k1_tcnt),
`endif
        .done      (k1_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Four beats, then CLEAR, 7 stream cycles, 4 drain cycles.
    // Returns at the negedge of the done cycle (12 after handshake).
    task automatic run_tile(input string tag, input bit hold);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            chk({tag, "_rdy"}, 32'(rdy), 32'd1);
            in_valid = 1'b1;
            in_a     = ta[b];
            in_b     = tbv[b];
        end
        @(negedge clk);
        if (hold) begin
            in_a = 32'h09090909;
            in_b = 32'h09090909;
        end else begin
            in_valid = 1'b0;
        end
        chk({tag, "_clr"}, 32'(clr), 32'd1);
        chk({tag, "_busy"}, 32'(bsy), 32'd1);
        chk({tag, "_rdy0"}, 32'(rdy), 32'd0);
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            chk($sformatf("%s_w%0d", tag, t), west, tw[t]);
            chk($sformatf("%s_n%0d", tag, t), north, tn[t]);
            chk($sformatf("%s_sr%0d", tag, t), 32'(rdy), 32'd0);
        end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk($sformatf("%s_dw%0d", tag, d), west | north, 32'd0);
            chk($sformatf("%s_dn%0d", tag, d), 32'(dn), 32'(d == 3));
            chk($sformatf("%s_dr%0d", tag, d), 32'(rdy), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        k1_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_out", west | north, 32'd0);
        chk("rst_flags", {29'd0, clr, bsy, dn}, 32'd0);
        rst = 1'b0;

        // abort mid-stream
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 32'h04030201;
            in_b     = 32'h01010101;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre", west, 32'h00030201);
        rst = 1'b1;
        #1;
        chk("abort_out", west | north, 32'd0);
        chk("abort_rdy", 32'(rdy), 32'd1);
        chk("abort_flags", {29'd0, clr, bsy, dn}, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (dn || bsy) seen = 1'b1;
        end
        chk("abort_nodone", 32'(seen), 32'd0);

        // tile 1: valid held high throughout
        ta  = '{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
        tbv = '{32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101};
        tw  = '{32'h00000001, 32'h00000201, 32'h00030201, 32'h04030201,
                32'h04030200, 32'h04030000, 32'h04000000};
        tn  = '{32'h00000001, 32'h00000101, 32'h00010101, 32'h01010101,
                32'h01010100, 32'h01010000, 32'h01000000};
        run_tile("t1", 1'b1);

        // tile 2: signed extremes, first beat lands right after done
        ta  = '{32'h00007F80, 32'h0000807F, 32'h00000000, 32'h00000000};
        tbv = '{32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
        tw  = '{32'h00000080, 32'h00007F7F, 32'h00008000, 32'h00000000,
                32'h00000000, 32'h00000000, 32'h00000000};
        tn  = '{32'h00000001, 32'h00000201, 32'h00030201, 32'h04030201,
                32'h04030200, 32'h04030000, 32'h04000000};
        run_tile("t2", 1'b0);

        // tile 3: distinct value per beat
        ta  = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        tbv = '{32'h0, 32'h0, 32'h0, 32'h0};
        tw  = '{32'h00000001, 32'h00000102, 32'h00010203, 32'h01020304,
                32'h02030400, 32'h03040000, 32'h04000000};
        tn  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        run_tile("t3", 1'b0);

`ifdef SYSTOLIC_FEEDER_TILE_CNT_EN
        chk("tcnt3", 32'(tcnt), 32'd3);
        @(negedge clk);
        force dut.r_tile_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_tile_cnt;
        run_tile("t4", 1'b0);
        chk("tcnt_wrap", 32'(tcnt), 32'd0);
`endif

        // K=1 instance: one beat, 4 stream cycles, done 9 after handshake
        @(negedge clk);
        in_valid = 1'b0;
        chk("k1_rdy", 32'(k1_rdy), 32'd1);
        k1_valid = 1'b1;
        in_a     = 32'h04030201;
        in_b     = 32'h01010101;
        @(negedge clk);
        k1_valid = 1'b0;
        chk("k1_clr", 32'(k1_clr), 32'd1);
        tw = '{32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000,
               32'h0, 32'h0, 32'h0};
        tn = '{32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000,
               32'h0, 32'h0, 32'h0};
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            chk($sformatf("k1_w%0d", t), k1_west, tw[t]);
            chk($sformatf("k1_n%0d", t), k1_north, tn[t]);
        end
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk($sformatf("k1_dw%0d", d), k1_west | k1_north, 32'd0);
            chk($sformatf("k1_dn%0d", d), 32'(k1_dn), 32'(d == 3));
        end
        @(negedge clk);
        chk("k1_idle", {30'd0, k1_rdy, k1_bsy}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
